instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the execute ALU in the MiniRiscV core.
- Owns the architectural PC and drives the synchronous-read instruction BRAM (1-cycle read latency).
- Presents the current instruction and its PC to decode/execute.
- Consumes execute's branch decision (doBranch, jmp) and operands to redirect the PC. Detects misaligned targets and halts.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IMEM_ADDR_W, 14, instruction BRAM word-address width
NOP_INSTR, 32'h0000_0013, instruction presented when instr_valid=0 (addi x0,x0,0)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  execute/memory not completing this cycle; hold current instruction
ex_do_branch  input  1  ALU doBranch for current instruction (taken branch, jal, or jalr)
ex_jmp  input  1  ALU jmp (current instruction is jalr)
ex_rs1  input  32  ReadData1 of current instruction
ex_imm32  input  32  immediate of current instruction
imem_addr  output  IMEM_ADDR_W  BRAM word address (combinational)
imem_rdata  input  32  BRAM read data (word addressed in previous cycle)
instr  output  32  current instruction to decode
pc  output  32  PC of instr; also the ALU pc operand
instr_valid  output  1  instr/pc hold a real instruction
misalign_err  output  1  sticky: redirect target not word aligned
fetch_count  output  32  count of instructions completed since reset

Behaviour:
- Registers: fetch_pc (next sequential address), pc, state ∈ {PRIME, RUN, HALT}, misalign_err, fetch_count.
- All arithmetic is 32-bit and wraps modulo 2^32.
- Reset (rst=1 at clock edge, overrides everything, including mid-stall or in HALT):
  - fetch_pc=RESET_PC, pc=RESET_PC, state=PRIME.
  - instr_valid=0, misalign_err=0, fetch_count=0.
- instr = instr_valid ? imem_rdata : NOP_INSTR (combinational pass-through).
- advance = (state==RUN) & ~stall. An instruction completes exactly when advance=1.
- take = advance & ex_do_branch. ex_* inputs are ignored whenever advance=0, so stall suppresses the redirect.
- target:
  - ex_jmp=1 (jalr): (ex_rs1 + ex_imm32) & ~32'h1.
  - otherwise (branch, jal): pc + ex_imm32.
- bad = take & (target[1] != 0).
- next_pc = take ? target : fetch_pc.
- imem_addr, combinational mux, priority order:
  - stall=1 or state==HALT: pc[IMEM_ADDR_W+1:2]. This re-reads the current word so instr stays stable.
  - otherwise: next_pc[IMEM_ADDR_W+1:2].
  - Address bits above IMEM_ADDR_W+1 are ignored (aliasing is allowed).
- PRIME (first cycle after reset; BRAM output not yet valid):
  - imem_addr = fetch_pc.
  - Next: pc<=fetch_pc, fetch_pc<=fetch_pc+4, instr_valid<=1, state<=RUN.
- RUN:
  - stall=1: pc, fetch_pc, instr_valid, fetch_count hold.
  - advance & ~bad: pc<=next_pc, fetch_pc<=next_pc+4, fetch_count<=fetch_count+1 (wraps).
  - advance & bad: misalign_err<=1, instr_valid<=0, state<=HALT. pc and fetch_pc hold. fetch_count still increments (the branch instruction completed).
- HALT:
  - Outputs frozen, instr=NOP_INSTR.
  - Leaves only via rst.
- Latency:
  - Sequential and redirected fetch both have zero bubbles. The redirect is combinational from ex_* into imem_addr.
  - First valid instruction appears 1 cycle after rst deasserts (the PRIME cycle).

Test Plan:
1. rst high 2 cycles, RESET_PC=0, mem[0..3]=I0..I3, no stall/branch.
   - Cycle after reset: instr_valid=0, instr=32'h13.
   - Following cycles: pc=0,4,8,12 with instr=I0..I3 each cycle.
   - fetch_count=3 at pc=12.
2. At pc=8, stall=1 for 3 cycles.
   - pc=8 and instr=I2 stable all 3 cycles; fetch_count frozen.
   - After stall drops: pc=12, instr=I3.
3. At pc=0x10, ex_do_branch=1, ex_jmp=0, ex_imm32=32'hFFFF_FFF8.
   - Next cycle pc=0x08, instr=mem[2]; the cycle after, pc=0x0C.
   - Repeat with stall=1 and ex_do_branch=1: no redirect.
4. jalr: ex_jmp=1, ex_do_branch=1, ex_rs1=0x101, ex_imm32=0x20.
   - target=0x120, next pc=0x120, misalign_err=0.
5. ex_jmp=0, ex_do_branch=1, pc=0x40, ex_imm32=0x6.
   - target=0x46: misalign_err=1, instr_valid=0, pc stays 0x40, HALT.
   - Further branches and stalls have no effect.
   - Then rst for 1 cycle: pc=RESET_PC, misalign_err=0, PRIME then RUN.
6. Assert rst during an active stall at pc=0x14.
   - Next cycle pc=RESET_PC, instr_valid=0, fetch_count=0.
   - Normal fetch from RESET_PC resumes afterwards.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the architectural PC, drives a 1-cycle-latency instruction BRAM,
// and applies execute-stage redirects with zero bubbles. A misaligned redirect target halts fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 14,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   ex_do_branch,
  input  logic                   ex_jmp,
  input  logic [31:0]            ex_rs1,
  input  logic [31:0]            ex_imm32,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr,
  output logic [31:0]            pc,
  output logic                   instr_valid,
  output logic                   misalign_err,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] pc_nx, count_nx;
  logic        valid_nx, mis_nx;
  logic        advance, take, bad;
  logic [31:0] target, next_pc;

  always_ff @(posedge clk) begin
    if (rst) state <= PRIME;
    else     state <= state_nx;
  end

  always_comb begin
    advance = (state == RUN) && !stall;
    take    = advance && ex_do_branch;
    target  = ex_jmp ? ((ex_rs1 + ex_imm32) & ~32'h1) : (pc + ex_imm32);
    bad     = take && target[1];
    next_pc = take ? target : fetch_pc;

    // Re-reading the current word keeps the BRAM output (and so instr) stable.
    if (stall || state == HALT) imem_addr = pc[IMEM_ADDR_W+1:2];
    else                        imem_addr = next_pc[IMEM_ADDR_W+1:2];

    instr = instr_valid ? imem_rdata : NOP_INSTR;
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    fetch_pc_nx = fetch_pc;
    valid_nx    = instr_valid;
    mis_nx      = misalign_err;
    count_nx    = fetch_count;
    unique case (state)
      PRIME: begin
        pc_nx       = fetch_pc;
        fetch_pc_nx = fetch_pc + 32'd4;
        valid_nx    = 1'b1;
        state_nx    = RUN;
      end
      RUN: begin
        if (advance) begin
          count_nx = fetch_count + 32'd1;
          if (bad) begin
            mis_nx   = 1'b1;
            valid_nx = 1'b0;
            state_nx = HALT;
          end else begin
            pc_nx       = next_pc;
            fetch_pc_nx = next_pc + 32'd4;
          end
        end
      end
      HALT: ;
      default: state_nx = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      fetch_pc     <= RESET_PC;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      pc           <= pc_nx;
      fetch_pc     <= fetch_pc_nx;
      instr_valid  <= valid_nx;
      misalign_err <= mis_nx;
      fetch_count  <= count_nx;
    end
  end

endmodule
